// File: rtl/query_buf_pkg.sv
// query_buf_pkg: shared query row buffer geometry and reader FSM states.
package query_buf_pkg;
  localparam int DATA_WIDTH = 55;
  localparam int ADDR_WIDTH = 7;
  localparam int DEPTH      = 128;
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;
endpackage

// File: rtl/fifo2_stream.sv
// fifo2_stream: 2-entry valid/ready FIFO with registered head and occupancy output.
module fifo2_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occ
);
  logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0] occ_q, occ_d;
  logic pop;
  always_comb begin
    out_valid = occ_q != 2'd0;
    out_data  = head_q;
    occ       = occ_q;
    pop       = out_valid && out_ready;
    head_d    = pop ? (occ_q == 2'd2 ? tail_q : (push ? in_data : head_q))
                    : (push && occ_q == 2'd0 ? in_data : head_q);
    tail_d    = (push && (pop ? occ_q == 2'd2 : occ_q == 2'd1)) ? in_data : tail_q;
    occ_d     = occ_q + 2'(push) - 2'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end
endmodule

// File: rtl/query_row_reader.sv
// query_row_reader: streams one row of query patches from the buffer SRAM over valid/ready.
module query_row_reader import query_buf_pkg::*; #(
  parameter int DATA_WIDTH = query_buf_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = query_buf_pkg::ADDR_WIDTH,
  parameter int DEPTH      = query_buf_pkg::DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_patches,
  output logic                  ren,
  output logic [ADDR_WIDTH-1:0] radr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_idx,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);
  localparam int FW = DATA_WIDTH + ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] MAX_CNT = (ADDR_WIDTH+1)'(DEPTH);
  state_e state_q, state_d;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d, rd_ptr_q, rd_ptr_d, req_cnt;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic inflight_q, inflight_d, pop, accept, in_last;
  logic [1:0] occ;
  logic [FW-1:0] fifo_out;
  always_comb begin
    pop        = out_valid && out_ready;
    accept     = state_q == IDLE && start;
    req_cnt    = num_patches > MAX_CNT ? MAX_CNT : num_patches;
    // Issue only while the FIFO can absorb this read once it lands.
    ren        = state_q == RUN && rd_ptr_q < cnt_q
                 && (3'(occ) + 3'(inflight_q) - 3'(pop)) < 3'd2;
    radr       = ren ? rd_ptr_q[ADDR_WIDTH-1:0] : '0;
    inflight_d = ren;
    idx_d      = ren ? radr : idx_q;
    rd_ptr_d   = accept ? '0 : rd_ptr_q + (ADDR_WIDTH+1)'(ren);
    cnt_d      = accept ? req_cnt : cnt_q;
    in_last    = {1'b0, idx_q} == cnt_q - (ADDR_WIDTH+1)'(1);
    state_d    = state_q == IDLE ? (accept ? (req_cnt == '0 ? FINISH : RUN) : IDLE)
               : state_q == RUN  ? (pop && out_last ? FINISH : RUN)
               : IDLE;
    {out_last, out_idx, out_data} = fifo_out;
    busy       = state_q != IDLE;
    done       = state_q == FINISH;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      idx_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      idx_q      <= idx_d;
      inflight_q <= inflight_d;
    end
  end
  fifo2_stream #(.WIDTH(FW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .in_data   ({in_last, idx_q, rdata}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (fifo_out),
    .occ       (occ)
  );
endmodule

// File: tb/tb_query_row_reader.sv
// tb_query_row_reader: directed scenarios for the query row reader with an SRAM model.
module tb_query_row_reader;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic [7:0] num_patches = '0;
  logic ren, out_valid, out_last, busy, done;
  logic [6:0] radr, out_idx;
  logic [54:0] rdata = '0, out_data;
  logic [54:0] mem [128];
  int total = 0, bad = 0;
  int got_data[$], got_idx[$], got_last[$];
  int done_k, done_cnt, first_valid_k, ren_cnt, max_radr, stall_bad, occ_bad, busy1, valid_cnt;

  always #5 clk = ~clk;
  always @(posedge clk) if (ren) rdata <= mem[radr];

  query_row_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_patches(num_patches),
    .ren(ren), .radr(radr), .rdata(rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .busy(busy), .done(done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready high, 1: ready 1,0,0,1 pattern, 2: ready high with start/num_patches disturbed at k=4
  task automatic run_row(input logic [7:0] np, input int mode, input int cycles);
    int outst, pv_stall, pv_idx, pv_last;
    logic [54:0] pv_data;
    got_data.delete(); got_idx.delete(); got_last.delete();
    done_k = -1; done_cnt = 0; first_valid_k = -1; ren_cnt = 0; max_radr = -1;
    stall_bad = 0; occ_bad = 0; busy1 = 0; valid_cnt = 0;
    outst = 0; pv_stall = 0; pv_idx = 0; pv_last = 0; pv_data = '0;
    num_patches = np;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= cycles; k++) begin
      out_ready = mode == 1 ? ((k - 1) % 4 == 0 || (k - 1) % 4 == 3) : 1'b1;
      start = mode == 2 && k == 4;
      if (mode == 2 && k == 4) num_patches = 8'd3;
      #1;
      if (k == 1) busy1 = busy;
      if (ren) begin
        ren_cnt++;
        if (int'(radr) > max_radr) max_radr = int'(radr);
        outst++;
      end
      if (pv_stall && !(out_valid && out_data == pv_data && int'(out_idx) == pv_idx && int'(out_last) == pv_last))
        stall_bad++;
      if (out_valid) begin
        valid_cnt++;
        if (first_valid_k < 0) first_valid_k = k;
      end
      if (out_valid && out_ready) begin
        got_data.push_back(int'(out_data));
        got_idx.push_back(int'(out_idx));
        got_last.push_back(int'(out_last));
        outst--;
      end
      if (outst > 2) occ_bad++;
      pv_stall = out_valid && !out_ready;
      pv_data = out_data; pv_idx = int'(out_idx); pv_last = int'(out_last);
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    total++; if (ren !== 1'b0) begin bad++; $display("FAIL reset_ren got=%b want=0", ren); end
    total++; if (radr !== 7'd0) begin bad++; $display("FAIL reset_radr got=%0d want=0", radr); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 55'd0) begin bad++; $display("FAIL reset_data got=%0d want=0", out_data); end
    total++; if ({busy, done, out_last} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {busy, done, out_last}); end
  endtask

  task automatic test_stream5;
    run_row(8'd5, 0, 14);
    total++; if (got_data.size() != 5) begin bad++; $display("FAIL s5_count got=%0d want=5", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < 5; i++) begin
      total++;
      if (got_data[i] != 100 + i || got_idx[i] != i || got_last[i] != (i == 4 ? 1 : 0)) begin
        bad++; $display("FAIL s5_patch%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", i, got_data[i], got_idx[i], got_last[i], 100 + i, i, i == 4);
      end
    end
    total++; if (first_valid_k != 3) begin bad++; $display("FAIL s5_first_valid got=%0d want=3", first_valid_k); end
    total++; if (done_k != 8 || done_cnt != 1) begin bad++; $display("FAIL s5_done got=k%0d n%0d want=k8 n1", done_k, done_cnt); end
    total++; if (ren_cnt != 5 || max_radr != 4) begin bad++; $display("FAIL s5_reads got=%0d max%0d want=5 max4", ren_cnt, max_radr); end
  endtask

  task automatic test_backpressure;
    int ok;
    run_row(8'd10, 1, 60);
    ok = got_data.size() == 10;
    for (int i = 0; i < got_data.size(); i++)
      if (got_data[i] != 100 + i || got_idx[i] != i || got_last[i] != (i == 9 ? 1 : 0)) ok = 0;
    total++; if (!ok) begin bad++; $display("FAIL bp_order got_count=%0d want=10 in order", got_data.size()); end
    total++; if (stall_bad != 0) begin bad++; $display("FAIL bp_stable got=%0d unstable stalls want=0", stall_bad); end
    total++; if (occ_bad != 0) begin bad++; $display("FAIL bp_occupancy got=%0d overflows want=0", occ_bad); end
    total++; if (done_cnt != 1 || ren_cnt != 10) begin bad++; $display("FAIL bp_done got=n%0d reads%0d want=n1 reads10", done_cnt, ren_cnt); end
  endtask

  task automatic test_zero;
    run_row(8'd0, 0, 6);
    total++; if (done_k != 1 || done_cnt != 1) begin bad++; $display("FAIL zero_done got=k%0d n%0d want=k1 n1", done_k, done_cnt); end
    total++; if (busy1 != 1) begin bad++; $display("FAIL zero_busy got=%0d want=1", busy1); end
    total++; if (ren_cnt != 0 || valid_cnt != 0) begin bad++; $display("FAIL zero_quiet got=ren%0d valid%0d want=0 0", ren_cnt, valid_cnt); end
  endtask

  task automatic test_clamp;
    run_row(8'd200, 0, 150);
    total++; if (got_data.size() != 128) begin bad++; $display("FAIL clamp_count got=%0d want=128", got_data.size()); end
    total++; if (ren_cnt != 128 || max_radr != 127) begin bad++; $display("FAIL clamp_reads got=%0d max%0d want=128 max127", ren_cnt, max_radr); end
    if (got_data.size() == 128) begin
      total++;
      if (got_idx[127] != 127 || got_last[127] != 1 || got_data[127] != 227 || got_last[126] != 0) begin
        bad++; $display("FAIL clamp_last got=%0d/%0d/%0d want=127/1/227", got_idx[127], got_last[127], got_data[127]);
      end
    end
    total++; if (done_k != 131) begin bad++; $display("FAIL clamp_done got=%0d want=131", done_k); end
  endtask

  task automatic test_ignore_restart;
    run_row(8'd6, 2, 20);
    total++; if (got_data.size() != 6 || got_idx[got_idx.size() - 1] != 5 || got_last[got_last.size() - 1] != 1) begin
      bad++; $display("FAIL restart_count got=%0d want=6 ending at idx5", got_data.size());
    end
    total++; if (done_cnt != 1 || done_k != 9) begin bad++; $display("FAIL restart_done got=k%0d n%0d want=k9 n1", done_k, done_cnt); end
  endtask

  task automatic test_async_reset;
    num_patches = 8'd8;
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    total++; if (out_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL rst_setup got=v%b b%b want=v1 b1", out_valid, busy); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({ren, out_valid, out_last, busy, done} !== 5'b0) begin bad++; $display("FAIL rst_flags got=%b want=00000", {ren, out_valid, out_last, busy, done}); end
    total++; if (radr !== 7'd0 || out_idx !== 7'd0 || out_data !== 55'd0) begin bad++; $display("FAIL rst_buses got=%0d/%0d/%0d want=0/0/0", radr, out_idx, out_data); end
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_drop got=v%b b%b want=v0 b0", out_valid, busy); end
    run_row(8'd3, 0, 10);
    total++; if (got_data.size() != 3) begin bad++; $display("FAIL rst_rerun_count got=%0d want=3", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < 3; i++) begin
      total++;
      if (got_data[i] != 100 + i || got_idx[i] != i || got_last[i] != (i == 2 ? 1 : 0)) begin
        bad++; $display("FAIL rst_rerun%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", i, got_data[i], got_idx[i], got_last[i], 100 + i, i, i == 2);
      end
    end
    total++; if (done_k != 6) begin bad++; $display("FAIL rst_rerun_done got=%0d want=6", done_k); end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 55'(i + 100);
    tick();
    tick();
    #2 rst_n = 1'b1;
    #1;
    test_reset();
    tick();
    test_stream5();
    test_backpressure();
    test_zero();
    test_clamp();
    test_ignore_restart();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
